// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller and its pattern generator.
package mem_bist_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] MODE_LFSR = 2'd0;
  localparam logic [1:0] MODE_ADDR = 2'd1;
  localparam logic [1:0] MODE_CHK  = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrSetup = 3'd1,
    StWrite   = 3'd2,
    StRdSetup = 3'd3,
    StRead    = 3'd4,
    StPassEnd = 3'd5,
    StHalt    = 3'd6
  } state_e;

endpackage

// File: rtl/mem_bist_ctrl_pattern_gen.sv
// Test-data source: an LFSR with save/restore for pass replay, plus the per-mode pattern mux.
module bist_pattern_gen
  import mem_bist_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned LFSR_LEN = 41,
  parameter int unsigned LFSR_TAP = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_i,
  input  logic              save_i,
  input  logic              restore_i,
  input  logic              next_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [CNT_W-1:0]  pass_cnt_i,
  output logic [DATA_W-1:0] pattern_o
);

  localparam int unsigned AddrExtW = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

  logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
  logic [LFSR_LEN-1:0] save_q, save_d;
  logic                fb;

  logic [DATA_W-1:0] addr_pat;
  logic [DATA_W-1:0] chk_base;
  logic [DATA_W-1:0] walk_pat;
  logic [31:0]       walk_sum;
  logic              pass_odd;

  assign fb       = lfsr_q[LFSR_LEN-1] ^ lfsr_q[LFSR_TAP-1];
  assign pass_odd = pass_cnt_i[0];

  always_comb begin
    lfsr_d = lfsr_q;
    save_d = save_q;
    if (init_i) begin
      lfsr_d = '1;
      save_d = '1;
    end else begin
      if (restore_i) begin
        lfsr_d = save_q;
      end else if (next_i) begin
        lfsr_d = {lfsr_q[LFSR_LEN-2:0], fb};
      end
      if (save_i) begin
        save_d = lfsr_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= '1;
      save_q <= '1;
    end else begin
      lfsr_q <= lfsr_d;
      save_q <= save_d;
    end
  end

  always_comb begin
    chk_base = '0;
    for (int i = 0; i < DATA_W; i++) begin
      chk_base[i] = ((i % 2) == 0);
    end
  end

  // Odd passes complement address data so stuck bits are exercised at both polarities.
  assign addr_pat = DATA_W'(addr_i[AddrExtW-1:0]) ^ {DATA_W{pass_odd}};
  assign walk_sum = 32'(addr_i) + 32'(pass_cnt_i);
  assign walk_pat = {{(DATA_W-1){1'b0}}, 1'b1} << (walk_sum % 32'(DATA_W));

  always_comb begin
    pattern_o = '0;
    unique case (mode_i)
      MODE_LFSR: pattern_o = lfsr_q[DATA_W-1:0];
      MODE_ADDR: pattern_o = addr_pat;
      MODE_CHK:  pattern_o = (addr_i[0] ^ pass_odd) ? ~chk_base : chk_base;
      MODE_WALK: pattern_o = walk_pat;
      default:   pattern_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: repeated write-all/read-all-compare passes with error capture and LED.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned LFSR_LEN = 41,
  parameter int unsigned LFSR_TAP = 3,
  parameter int unsigned LED_DIV  = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              stop_on_err_i,
  input  logic              clr_i,
  output logic              mem_req_o,
  output logic              mem_rnw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdat_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdat_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              err_flag_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] first_err_exp_o,
  output logic [DATA_W-1:0] first_err_got_o,
  output logic              led_o
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         mode_q, mode_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]  fe_addr_q, fe_addr_d;
  logic [DATA_W-1:0]  fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0]  fe_got_q, fe_got_d;
  logic [LED_DIV-1:0] led_cnt_q, led_cnt_d;
  logic               led_q;

  logic [DATA_W-1:0] pattern;
  logic              ack_fire;
  logic              last_addr;
  logic              mismatch;
  logic              clr_ok;
  logic              in_access;

  // Acks outside an outstanding request are ignored.
  assign ack_fire  = req_q & mem_ack_i;
  assign last_addr = &addr_q;
  assign in_access = (state_q == StWrite) || (state_q == StRead);
  assign mismatch  = (state_q == StRead) && ack_fire && (mem_rdat_i != pattern);
  assign clr_ok    = clr_i && ((state_q == StIdle) || (state_q == StHalt));

  bist_pattern_gen #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LFSR_LEN(LFSR_LEN),
    .LFSR_TAP(LFSR_TAP)
  ) u_pattern_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .init_i    (clr_ok),
    .save_i    (state_q == StWrSetup),
    .restore_i (state_q == StRdSetup),
    .next_i    (in_access && ack_fire && (mode_q == MODE_LFSR)),
    .mode_i    (mode_q),
    .addr_i    (addr_q),
    .pass_cnt_i(pass_cnt_q),
    .pattern_o (pattern)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    req_d      = req_q;
    pass_cnt_d = pass_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    fe_addr_d  = fe_addr_q;
    fe_exp_d   = fe_exp_q;
    fe_got_d   = fe_got_q;
    led_cnt_d  = led_cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        req_d = 1'b0;
        if (start_i) begin
          mode_d  = mode_i;
          state_d = StWrSetup;
        end
      end
      StWrSetup: begin
        addr_d  = '0;
        state_d = StWrite;
      end
      StWrite: begin
        req_d = 1'b1;
        if (ack_fire) begin
          addr_d = addr_q + 1'b1;
          if (last_addr) begin
            req_d   = 1'b0;
            state_d = StRdSetup;
          end
        end
      end
      StRdSetup: begin
        addr_d  = '0;
        state_d = StRead;
      end
      StRead: begin
        req_d = 1'b1;
        if (ack_fire) begin
          // A failing last address halts rather than closing the pass.
          if (mismatch && stop_on_err_i) begin
            req_d   = 1'b0;
            state_d = StHalt;
          end else if (last_addr) begin
            addr_d  = '0;
            req_d   = 1'b0;
            state_d = StPassEnd;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StPassEnd: begin
        pass_cnt_d = pass_cnt_q + 1'b1;
        led_cnt_d  = '0;
        if (start_i) begin
          mode_d  = mode_i;
          state_d = StWrSetup;
        end else begin
          state_d = StIdle;
        end
      end
      StHalt: begin
        req_d = 1'b0;
        if (!start_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (mismatch) begin
      if (err_cnt_q != {CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (!err_flag_q) begin
        err_flag_d = 1'b1;
        fe_addr_d  = addr_q;
        fe_exp_d   = pattern;
        fe_got_d   = mem_rdat_i;
      end
    end

    if (clr_ok) begin
      pass_cnt_d = '0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
      fe_addr_d  = '0;
      fe_exp_d   = '0;
      fe_got_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      mode_q     <= MODE_LFSR;
      req_q      <= 1'b0;
      pass_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      fe_addr_q  <= '0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
      led_cnt_q  <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      req_q      <= req_d;
      pass_cnt_q <= pass_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      fe_addr_q  <= fe_addr_d;
      fe_exp_q   <= fe_exp_d;
      fe_got_q   <= fe_got_d;
      led_cnt_q  <= led_cnt_d;
      led_q      <= led_cnt_q[LED_DIV-1] ^ err_flag_q;
    end
  end

  assign mem_req_o        = req_q;
  assign mem_rnw_o        = (state_q == StRead);
  assign mem_addr_o       = addr_q;
  assign mem_wdat_o       = (state_q == StWrite) ? pattern : '0;
  assign busy_o           = (state_q != StIdle);
  assign pass_cnt_o       = pass_cnt_q;
  assign err_cnt_o        = err_cnt_q;
  assign err_flag_o       = err_flag_q;
  assign first_err_addr_o = fe_addr_q;
  assign first_err_exp_o  = fe_exp_q;
  assign first_err_got_o  = fe_got_q;
  assign led_o            = led_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: 16-entry memory model with fault injection and random wait states.
module tb_mem_bist_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic        stop_on_err_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        mem_req_o;
  logic        mem_rnw_o;
  logic [3:0]  mem_addr_o;
  logic [7:0]  mem_wdat_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdat_i = 8'h00;
  logic        busy_o;
  logic [15:0] pass_cnt_o;
  logic [15:0] err_cnt_o;
  logic        err_flag_o;
  logic [3:0]  first_err_addr_o;
  logic [7:0]  first_err_exp_o;
  logic [7:0]  first_err_got_o;
  logic        led_o;

  mem_bist_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .LFSR_LEN(41),
    .LFSR_TAP(3),
    .LED_DIV (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .mode_i          (mode_i),
    .stop_on_err_i   (stop_on_err_i),
    .clr_i           (clr_i),
    .mem_req_o       (mem_req_o),
    .mem_rnw_o       (mem_rnw_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdat_o      (mem_wdat_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rdat_i      (mem_rdat_i),
    .busy_o          (busy_o),
    .pass_cnt_o      (pass_cnt_o),
    .err_cnt_o       (err_cnt_o),
    .err_flag_o      (err_flag_o),
    .first_err_addr_o(first_err_addr_o),
    .first_err_exp_o (first_err_exp_o),
    .first_err_got_o (first_err_got_o),
    .led_o           (led_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Memory model controls
  bit       fault_en = 1'b0;
  int       fault_addr = 5;
  bit       rnd_wait = 1'b0;
  logic [7:0] mem [16];
  int       wcnt = 0;

  always @(posedge clk_i) begin
    mem_ack_i <= 1'b0;
    if (mem_req_o && !mem_ack_i) begin
      if (wcnt == 0) begin
        mem_ack_i <= 1'b1;
        if (mem_rnw_o) begin
          mem_rdat_i <= mem[mem_addr_o] ^
                        ((fault_en && int'(mem_addr_o) == fault_addr) ? 8'h08 : 8'h00);
        end else begin
          mem[mem_addr_o] <= mem_wdat_o;
        end
        wcnt <= rnd_wait ? int'($urandom_range(0, 3)) : 0;
      end else begin
        wcnt <= wcnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model of the data stream
  logic [40:0] lfsr_m = '1;
  logic [40:0] save_m = '1;
  int          pc_m = 0;
  logic [3:0]  sb_q[$];
  logic [7:0]  wd0_q[$];
  int          led_tog = 0;

  function automatic logic [40:0] lfsr_step(input logic [40:0] l);
    return {l[39:0], l[40] ^ l[2]};
  endfunction

  function automatic logic [7:0] model_pat(input int m, input int a, input int pc,
                                           input logic [40:0] l);
    logic [7:0] one;
    one = 8'h01;
    case (m)
      0: return l[7:0];
      1: return 8'(a) ^ ((pc % 2) == 1 ? 8'hFF : 8'h00);
      2: return (((a % 2) ^ (pc % 2)) == 1) ? 8'hAA : 8'h55;
      default: return one << ((a + pc) % 8);
    endcase
  endfunction

  logic       req_p = 1'b0;
  logic       ack_p = 1'b0;
  logic [3:0] addr_p = '0;
  logic [7:0] wdat_p = '0;
  logic       led_p = 1'b0;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mem_req_o && req_p && !ack_p) begin
        checks++;
        if (mem_addr_o !== addr_p || mem_wdat_o !== wdat_p) begin
          errors++;
          $display("FAIL stall_stable: addr %0h wdat %0h, held %0h %0h",
                   mem_addr_o, mem_wdat_o, addr_p, wdat_p);
        end
      end
      if (mem_req_o && mem_ack_i && !mem_rnw_o) begin
        if (mem_addr_o == 4'd0) begin
          save_m = lfsr_m;
          wd0_q.push_back(mem_wdat_o);
        end
        check("sb_wdat", 32'(mem_wdat_o),
              32'(model_pat(int'(mode_i), int'(mem_addr_o), pc_m, lfsr_m)));
        sb_q.push_back(mem_addr_o);
        if (mode_i == 2'd0) lfsr_m = lfsr_step(lfsr_m);
      end
      if (mem_req_o && mem_ack_i && mem_rnw_o) begin
        if (mem_addr_o == 4'd0) lfsr_m = save_m;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: read at %0h with no write recorded", mem_addr_o);
        end else begin
          check("sb_rd_order", 32'(mem_addr_o), 32'(sb_q.pop_front()));
        end
        if (mode_i == 2'd0) lfsr_m = lfsr_step(lfsr_m);
        if (mem_addr_o == 4'd15 &&
            !(stop_on_err_i && fault_en && int'(mem_addr_o) == fault_addr)) pc_m++;
      end
      if (led_o !== led_p) led_tog++;
    end
    req_p  = mem_req_o;
    ack_p  = mem_ack_i;
    addr_p = mem_addr_o;
    wdat_p = mem_wdat_o;
    led_p  = led_o;
  end

  task automatic model_reset();
    lfsr_m = '1;
    save_m = '1;
    pc_m = 0;
    sb_q.delete();
    wd0_q.delete();
  endtask

  task automatic do_clr();
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    model_reset();
  endtask

  task automatic run_passes(input int n);
    int k;
    start_i = 1'b1;
    k = 0;
    while (!busy_o && k < 20) begin @(negedge clk_i); k++; end
    if (!busy_o) check("timeout_busy", 0, 1);
    k = 0;
    while (int'(pass_cnt_o) != n - 1 && busy_o && k < 4000) begin @(negedge clk_i); k++; end
    if (k >= 4000) check("timeout_pass", 32'(pass_cnt_o), 32'(n - 1));
    start_i = 1'b0;
    k = 0;
    while (busy_o && k < 4000) begin @(negedge clk_i); k++; end
    if (busy_o) check("timeout_idle", 32'(busy_o), 0);
  endtask

  typedef struct {
    int mode; bit fault; int faddr; bit rnd; int passes;
    int exp_pass; int exp_err; int exp_flag; int exp_fa; int exp_fe; int exp_fg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k;
    vecs[0] = '{2, 0, 5, 0, 2, 2, 0, 0, 0, 'h00, 'h00};
    vecs[1] = '{0, 0, 5, 0, 2, 2, 0, 0, 0, 'h00, 'h00};
    vecs[2] = '{1, 1, 5, 0, 3, 3, 3, 1, 5, 'h05, 'h0D};
    vecs[3] = '{3, 0, 5, 1, 2, 2, 0, 0, 0, 'h00, 'h00};
    vecs[4] = '{1, 0, 5, 1, 2, 2, 0, 0, 0, 'h00, 'h00};
    vecs[5] = '{2, 1, 5, 0, 1, 1, 1, 1, 5, 'hAA, 'hA2};
    vecs[6] = '{3, 1, 15, 1, 1, 1, 1, 1, 15, 'h80, 'h88};

    #12;
    check("rst_req", 32'(mem_req_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_outs", {pass_cnt_o, err_cnt_o}, 0);
    check("rst_misc", {err_flag_o, led_o, mem_rnw_o, mem_addr_o, mem_wdat_o}, 0);
    check("rst_cap", {first_err_addr_o, first_err_exp_o, first_err_got_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      stop_on_err_i = 1'b0;
      fault_en = vecs[i].fault;
      fault_addr = vecs[i].faddr;
      rnd_wait = vecs[i].rnd;
      mode_i = 2'(vecs[i].mode);
      do_clr();
      led_tog = 0;
      run_passes(vecs[i].passes);
      check($sformatf("v%0d_pass", i), 32'(pass_cnt_o), 32'(vecs[i].exp_pass));
      check($sformatf("v%0d_err", i), 32'(err_cnt_o), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_flag", i), 32'(err_flag_o), 32'(vecs[i].exp_flag));
      check($sformatf("v%0d_faddr", i), 32'(first_err_addr_o), 32'(vecs[i].exp_fa));
      check($sformatf("v%0d_fexp", i), 32'(first_err_exp_o), 32'(vecs[i].exp_fe));
      check($sformatf("v%0d_fgot", i), 32'(first_err_got_o), 32'(vecs[i].exp_fg));
      check($sformatf("v%0d_sb_drain", i), 32'(sb_q.size()), 0);
      if (i == 0) check("led_toggles", 32'(led_tog > 0), 1);
      if (i == 1) begin
        check("lfsr_wd0_count", 32'(wd0_q.size()), 2);
        if (wd0_q.size() == 2) begin
          check("lfsr_seed_data", 32'(wd0_q[0]), 32'h0FF);
          check("lfsr_pass2_differs", 32'(wd0_q[1] != wd0_q[0]), 1);
        end
      end
    end

    // Stop on error: halt on read ack at addr 5, clr honoured in HALT
    fault_en = 1'b1; fault_addr = 5; rnd_wait = 1'b0;
    mode_i = 2'd1; stop_on_err_i = 1'b1;
    do_clr();
    start_i = 1'b1;
    k = 0;
    while (!(mem_req_o && mem_ack_i && mem_rnw_o && mem_addr_o == 4'd5) && k < 1000) begin
      @(negedge clk_i); k++;
    end
    if (k >= 1000) check("timeout_halt_ack", 0, 1);
    @(negedge clk_i);
    check("halt_req_low", 32'(mem_req_o), 0);
    repeat (4) @(negedge clk_i);
    check("halt_busy", 32'(busy_o), 1);
    check("halt_req_stays", 32'(mem_req_o), 0);
    check("halt_pass", 32'(pass_cnt_o), 0);
    check("halt_err", 32'(err_cnt_o), 1);
    check("halt_cap", {first_err_addr_o, first_err_exp_o, first_err_got_o}, {4'd5, 8'h05, 8'h0D});
    do_clr();
    check("halt_clr_err", 32'(err_cnt_o), 0);
    check("halt_clr_flag", 32'(err_flag_o), 0);
    check("halt_clr_busy", 32'(busy_o), 1);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("halt_to_idle", 32'(busy_o), 0);

    // clr outside IDLE/HALT is ignored
    stop_on_err_i = 1'b0;
    start_i = 1'b1;
    k = 0;
    while (int'(pass_cnt_o) != 1 && k < 2000) begin @(negedge clk_i); k++; end
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    check("clr_ignored_busy", {pass_cnt_o, err_cnt_o}, {16'd1, 16'd1});

    // Reset mid-write at addr 7
    k = 0;
    while (!(mem_req_o && !mem_rnw_o && mem_addr_o == 4'd7) && k < 2000) begin
      @(negedge clk_i); k++;
    end
    if (k >= 2000) check("timeout_addr7", 0, 1);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rstmid_req", 32'(mem_req_o), 0);
    check("rstmid_busy", 32'(busy_o), 0);
    check("rstmid_cnts", {pass_cnt_o, err_cnt_o}, 0);
    check("rstmid_flag", 32'(err_flag_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    k = 0;
    while (!mem_req_o && k < 20) begin @(negedge clk_i); k++; end
    check("rstmid_restart_addr", {mem_req_o, mem_rnw_o, mem_addr_o}, {1'b1, 1'b0, 4'd0});
    run_passes(1);
    check("rstmid_pass", 32'(pass_cnt_o), 1);
    check("rstmid_err", 32'(err_cnt_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
